conv_window_gen: RTL and testbench

//  Streaming 3x3 window generator that sits directly upstream of the 3x3 convolution stage.

---
 rtl/conv_pkg.sv | 33 +++
 rtl/conv_window_gen_if.sv | 54 +++++
 rtl/conv_line_buffer.sv | 25 ++
 rtl/conv_window_gen.sv | 123 ++++++++++++
 tb/tb_conv_window_gen.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution datapath: pixel width, tap numbering
// and the window bus packing helpers used by the window generator and the conv stage.
package conv_pkg;

    localparam int WIN_TAPS = 9;

    // Tap k = 3*row + col, row 0 being the oldest image row and col 0 the leftmost column.
    localparam int TAP_TL = 0;
    localparam int TAP_TM = 1;
    localparam int TAP_TR = 2;
    localparam int TAP_ML = 3;
    localparam int TAP_MM = 4;
    localparam int TAP_MR = 5;
    localparam int TAP_BL = 6;
    localparam int TAP_BM = 7;
    localparam int TAP_BR = 8;

    function automatic int calc_dw(input int integer_bits, input int fixed_point_bits);
        return integer_bits + fixed_point_bits;
    endfunction

    localparam int DW_DEFAULT = calc_dw(8, 4);

    function automatic int tap_of(input int row, input int col);
        return 3 * row + col;
    endfunction

    // Bit offset of a tap inside the packed WIN_TAPS*dw window bus.
    function automatic int tap_lsb(input int tap, input int dw);
        return tap * dw;
    endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out stream bundle of the 3x3 window generator.
// The i_sof signal exists only when CONV_WIN_SOF_EN is defined.
interface conv_window_gen_if
    import conv_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) ();

    logic [DW-1:0]          i_pixel;
    logic                   i_pixel_valid;
`ifdef CONV_WIN_SOF_EN
    logic                   i_sof;
`endif
    logic [WIN_TAPS*DW-1:0] o_pixel_data;
    logic                   o_pixel_data_valid;
    logic                   o_frame_done;

`ifdef CONV_WIN_SOF_EN
    modport master (
        output i_pixel,
        output i_pixel_valid,
        output i_sof,
        input  o_pixel_data,
        input  o_pixel_data_valid,
        input  o_frame_done
    );

    modport slave (
        input  i_pixel,
        input  i_pixel_valid,
        input  i_sof,
        output o_pixel_data,
        output o_pixel_data_valid,
        output o_frame_done
    );
`else
    modport master (
        output i_pixel,
        output i_pixel_valid,
        input  o_pixel_data,
        input  o_pixel_data_valid,
        input  o_frame_done
    );

    modport slave (
        input  i_pixel,
        input  i_pixel_valid,
        output o_pixel_data,
        output o_pixel_data_valid,
        output o_frame_done
    );
`endif

endinterface

// File: rtl/conv_line_buffer.sv
// Single image-row store: one combined read/write address per cycle, the read
// returns the value held before this cycle's write. Contents are never reset.
module conv_line_buffer #(
    parameter int DEPTH = 28,
    parameter int DW    = 12,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_addr];

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 "valid" window generator for raster-order pixels, one window per
// accepted pixel at row>=2, col>=2. Define CONV_WIN_SOF_EN to add the i_sof resync input.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int INTEGER_BITS     = 8,
    parameter int FIXED_POINT_BITS = 4,
    parameter int IMG_WIDTH        = 28,
    parameter int IMG_HEIGHT       = 28
) (
    input logic              i_clk,
    input logic              i_rst_n,
    conv_window_gen_if.slave pix_if
);

    localparam int DW = calc_dw(INTEGER_BITS, FIXED_POINT_BITS);
    localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_WIN  = CW'(2);
    localparam logic [RW-1:0] ROW_WIN  = RW'(2);

    logic          accept;
    logic          sof;
    logic [CW-1:0] col_q, pos_col, col_d;
    logic [RW-1:0] row_q, pos_row, row_d;
    logic [DW-1:0] lba_rd, lbb_rd;
    logic [DW-1:0] win_q [WIN_TAPS];
    logic [DW-1:0] win_d [WIN_TAPS];
    logic [WIN_TAPS*DW-1:0] win_bus;
    logic          valid_q;
    logic          done_q;

    assign accept = pix_if.i_pixel_valid;

`ifdef CONV_WIN_SOF_EN
    assign sof = pix_if.i_sof;
`else
    assign sof = 1'b0;
`endif

    // A start-of-frame pixel is treated as (0,0) whatever the counters say.
    always_comb begin
        pos_col = sof ? '0 : col_q;
        pos_row = sof ? '0 : row_q;
        col_d   = pos_col + CW'(1);
        row_d   = pos_row;
        if (pos_col == COL_LAST) begin
            col_d = '0;
            row_d = (pos_row == ROW_LAST) ? '0 : pos_row + RW'(1);
        end
    end

    // lbA holds row-2 and lbB row-1; on each accept the column ages one row.
    conv_line_buffer #(
        .DEPTH (IMG_WIDTH),
        .DW    (DW),
        .AW    (CW)
    ) u_lb_a (
        .i_clk   (i_clk),
        .i_we    (accept),
        .i_addr  (pos_col),
        .i_wdata (lbb_rd),
        .o_rdata (lba_rd)
    );

    conv_line_buffer #(
        .DEPTH (IMG_WIDTH),
        .DW    (DW),
        .AW    (CW)
    ) u_lb_b (
        .i_clk   (i_clk),
        .i_we    (accept),
        .i_addr  (pos_col),
        .i_wdata (pix_if.i_pixel),
        .o_rdata (lbb_rd)
    );

    always_comb begin
        win_d = win_q;
        for (int r = 0; r < 3; r++) begin
            win_d[tap_of(r, 0)] = win_q[tap_of(r, 1)];
            win_d[tap_of(r, 1)] = win_q[tap_of(r, 2)];
        end
        win_d[TAP_TR] = lba_rd;
        win_d[TAP_MR] = lbb_rd;
        win_d[TAP_BR] = pix_if.i_pixel;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            for (int k = 0; k < WIN_TAPS; k++) begin
                win_q[k] <= '0;
            end
        end else begin
            valid_q <= accept && (pos_row >= ROW_WIN) && (pos_col >= COL_WIN);
            done_q  <= accept && (pos_row == ROW_LAST) && (pos_col == COL_LAST);
            if (accept) begin
                col_q <= col_d;
                row_q <= row_d;
                win_q <= win_d;
            end
        end
    end

    always_comb begin
        win_bus = '0;
        for (int k = 0; k < WIN_TAPS; k++) begin
            win_bus[tap_lsb(k, DW) +: DW] = win_q[k];
        end
    end

    assign pix_if.o_pixel_data       = win_bus;
    assign pix_if.o_pixel_data_valid = valid_q;
    assign pix_if.o_frame_done       = done_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench for conv_window_gen on a 4x4 image with a scoreboard queue of
// expected windows; the resync scenario is compiled in only with CONV_WIN_SOF_EN.
module tb_conv_window_gen;
    import conv_pkg::*;

    localparam int IB = 8;
    localparam int FB = 4;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int DW = calc_dw(IB, FB);
    localparam int WD = WIN_TAPS * DW;
    localparam int WINS_PER_FRAME = (H - 2) * (W - 2);

    localparam int FIRST_TAPS [9]  = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    localparam int LAST_TAPS [9]   = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
    localparam int SECOND_TAPS [9] = '{100, 101, 102, 104, 105, 106, 108, 109, 110};

    typedef struct {
        logic [WD-1:0] data;
        logic          done;
    } exp_t;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;

    always #5 i_clk = ~i_clk;

    conv_window_gen_if #(.DW(DW)) pix_if ();

    conv_window_gen #(
        .INTEGER_BITS     (IB),
        .FIXED_POINT_BITS (FB),
        .IMG_WIDTH        (W),
        .IMG_HEIGHT       (H)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .pix_if  (pix_if)
    );

    exp_t          exp_q [$];
    int            n_compared   = 0;
    int            n_mismatched = 0;
    int            m_row, m_col;
    logic [DW-1:0] img [H][W];
    logic          fired;
    logic          hold_known;
    logic [WD-1:0] last_win;

    function automatic logic [DW-1:0] px(input int p);
        return DW'(p) << FB;
    endfunction

    function automatic logic [WD-1:0] pack_taps(input int t [9]);
        logic [WD-1:0] v;
        v = '0;
        for (int k = 0; k < 9; k++) begin
            v[k*DW +: DW] = px(t[k]);
        end
        return v;
    endfunction

    task automatic model_reset();
        m_row      = 0;
        m_col      = 0;
        hold_known = 1'b0;
        exp_q.delete();
    endtask

    // Drive one cycle (valid pixel or idle), update the image model and push any window it completes.
    task automatic send(input logic valid, input int p, input logic sof);
        exp_t e;
        @(negedge i_clk);
        pix_if.i_pixel       = valid ? px(p) : DW'($urandom);
        pix_if.i_pixel_valid = valid;
`ifdef CONV_WIN_SOF_EN
        pix_if.i_sof         = sof;
`endif
        fired = 1'b0;
        if (valid) begin
            if (sof) begin
                m_row = 0;
                m_col = 0;
            end
            img[m_row][m_col] = px(p);
            if (m_row >= 2 && m_col >= 2) begin
                for (int r = 0; r < 3; r++) begin
                    for (int c = 0; c < 3; c++) begin
                        e.data[(3*r + c)*DW +: DW] = img[m_row - 2 + r][m_col - 2 + c];
                    end
                end
                e.done = (m_row == H - 1) && (m_col == W - 1);
                exp_q.push_back(e);
                fired = 1'b1;
            end
            if (m_col == W - 1) begin
                m_col = 0;
                m_row = (m_row == H - 1) ? 0 : m_row + 1;
            end else begin
                m_col++;
            end
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        pix_if.i_pixel       = px(7);
        pix_if.i_pixel_valid = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        n_compared++;
        if (pix_if.o_pixel_data_valid !== 1'b0 || pix_if.o_frame_done !== 1'b0 || pix_if.o_pixel_data !== '0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_outputs: got valid=%b done=%b data=%h, want 0/0/0",
                     pix_if.o_pixel_data_valid, pix_if.o_frame_done, pix_if.o_pixel_data);
        end
        @(negedge i_clk);
        pix_if.i_pixel_valid = 1'b0;
        i_rst_n = 1'b1;
        model_reset();
        send(1'b0, 0, 1'b0);
        n_compared++;
        if (pix_if.o_pixel_data_valid !== 1'b0 || pix_if.o_pixel_data !== '0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_idle: got valid=%b data=%h, want 0/0",
                     pix_if.o_pixel_data_valid, pix_if.o_pixel_data);
        end
    endtask

    task automatic test_continuous_frame();
        exp_t e;
        int   dut_wins = 0;
        int   dut_dones = 0;
        for (int p = 0; p < 16; p++) begin
            send(1'b1, p, 1'b0);
            n_compared++;
            if (fired) begin
                e = exp_q.pop_front();
                if (pix_if.o_pixel_data_valid !== 1'b1 || pix_if.o_pixel_data !== e.data || pix_if.o_frame_done !== e.done) begin
                    n_mismatched++;
                    $display("[TB] FAIL cont_window p=%0d: got v=%b d=%b data=%h, want v=1 d=%b data=%h",
                             p, pix_if.o_pixel_data_valid, pix_if.o_frame_done, pix_if.o_pixel_data, e.done, e.data);
                end
            end else if (pix_if.o_pixel_data_valid !== 1'b0 || pix_if.o_frame_done !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL cont_quiet p=%0d: got v=%b d=%b, want 0/0", p,
                         pix_if.o_pixel_data_valid, pix_if.o_frame_done);
            end
            if (pix_if.o_pixel_data_valid === 1'b1 && dut_wins == 0) begin
                n_compared++;
                if (pix_if.o_pixel_data !== pack_taps(FIRST_TAPS)) begin
                    n_mismatched++;
                    $display("[TB] FAIL cont_first_window: got %h, want %h", pix_if.o_pixel_data, pack_taps(FIRST_TAPS));
                end
            end
            if (pix_if.o_frame_done === 1'b1) begin
                n_compared++;
                if (p != 15 || pix_if.o_pixel_data !== pack_taps(LAST_TAPS)) begin
                    n_mismatched++;
                    $display("[TB] FAIL cont_last_window p=%0d: got %h, want p=15 data %h",
                             p, pix_if.o_pixel_data, pack_taps(LAST_TAPS));
                end
            end
            dut_wins  += int'(pix_if.o_pixel_data_valid === 1'b1);
            dut_dones += int'(pix_if.o_frame_done === 1'b1);
        end
        send(1'b0, 0, 1'b0);
        n_compared++;
        if (pix_if.o_frame_done !== 1'b0 || pix_if.o_pixel_data_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL cont_done_pulse: got v=%b d=%b after last window, want 0/0",
                     pix_if.o_pixel_data_valid, pix_if.o_frame_done);
        end
        n_compared++;
        if (dut_wins != WINS_PER_FRAME || dut_dones != 1) begin
            n_mismatched++;
            $display("[TB] FAIL cont_counts: got wins=%0d dones=%0d, want %0d/1", dut_wins, dut_dones, WINS_PER_FRAME);
        end
    endtask

    task automatic test_idle_gaps();
        exp_t e;
        int   dut_wins = 0;
        for (int p = 0; p < 16; p++) begin
            repeat ($urandom_range(0, 2)) begin
                send(1'b0, 0, 1'b0);
                n_compared++;
                if (pix_if.o_pixel_data_valid !== 1'b0 || pix_if.o_frame_done !== 1'b0 ||
                    (hold_known && pix_if.o_pixel_data !== last_win)) begin
                    n_mismatched++;
                    $display("[TB] FAIL idle_hold p=%0d: got v=%b d=%b data=%h, want 0/0 data %h",
                             p, pix_if.o_pixel_data_valid, pix_if.o_frame_done, pix_if.o_pixel_data, last_win);
                end
            end
            send(1'b1, p, 1'b0);
            n_compared++;
            hold_known = fired;
            if (fired) begin
                e = exp_q.pop_front();
                last_win = e.data;
                if (pix_if.o_pixel_data_valid !== 1'b1 || pix_if.o_pixel_data !== e.data || pix_if.o_frame_done !== e.done) begin
                    n_mismatched++;
                    $display("[TB] FAIL idle_window p=%0d: got v=%b d=%b data=%h, want v=1 d=%b data=%h",
                             p, pix_if.o_pixel_data_valid, pix_if.o_frame_done, pix_if.o_pixel_data, e.done, e.data);
                end
            end else if (pix_if.o_pixel_data_valid !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL idle_quiet p=%0d: got v=%b, want 0", p, pix_if.o_pixel_data_valid);
            end
            dut_wins += int'(pix_if.o_pixel_data_valid === 1'b1);
        end
        n_compared++;
        if (dut_wins != WINS_PER_FRAME) begin
            n_mismatched++;
            $display("[TB] FAIL idle_counts: got wins=%0d, want %0d", dut_wins, WINS_PER_FRAME);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   dut_wins = 0;
        int   p;
        for (int i = 0; i < 32; i++) begin
            p = (i < 16) ? i : 100 + i - 16;
            send(1'b1, p, 1'b0);
            n_compared++;
            if (fired) begin
                e = exp_q.pop_front();
                if (pix_if.o_pixel_data_valid !== 1'b1 || pix_if.o_pixel_data !== e.data || pix_if.o_frame_done !== e.done) begin
                    n_mismatched++;
                    $display("[TB] FAIL b2b_window p=%0d: got v=%b d=%b data=%h, want v=1 d=%b data=%h",
                             p, pix_if.o_pixel_data_valid, pix_if.o_frame_done, pix_if.o_pixel_data, e.done, e.data);
                end
            end else if (pix_if.o_pixel_data_valid !== 1'b0 || pix_if.o_frame_done !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL b2b_quiet p=%0d: got v=%b d=%b, want 0/0", p,
                         pix_if.o_pixel_data_valid, pix_if.o_frame_done);
            end
            if (pix_if.o_pixel_data_valid === 1'b1 && dut_wins == WINS_PER_FRAME) begin
                n_compared++;
                if (pix_if.o_pixel_data !== pack_taps(SECOND_TAPS)) begin
                    n_mismatched++;
                    $display("[TB] FAIL b2b_second_first: got %h, want %h", pix_if.o_pixel_data, pack_taps(SECOND_TAPS));
                end
            end
            dut_wins += int'(pix_if.o_pixel_data_valid === 1'b1);
        end
        n_compared++;
        if (dut_wins != 2 * WINS_PER_FRAME) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_counts: got wins=%0d, want %0d", dut_wins, 2 * WINS_PER_FRAME);
        end
    endtask

    task automatic test_mid_frame_reset();
        exp_t e;
        int   dut_wins = 0;
        for (int p = 0; p < 10; p++) begin
            send(1'b1, p, 1'b0);
        end
        @(negedge i_clk);
        i_rst_n = 1'b0;
        pix_if.i_pixel       = px(3);
        pix_if.i_pixel_valid = 1'b1;
        #1;
        n_compared++;
        if (pix_if.o_pixel_data_valid !== 1'b0 || pix_if.o_frame_done !== 1'b0 || pix_if.o_pixel_data !== '0) begin
            n_mismatched++;
            $display("[TB] FAIL rst_async: got v=%b d=%b data=%h, want 0/0/0",
                     pix_if.o_pixel_data_valid, pix_if.o_frame_done, pix_if.o_pixel_data);
        end
        @(posedge i_clk);
        #1;
        n_compared++;
        if (pix_if.o_pixel_data_valid !== 1'b0 || pix_if.o_pixel_data !== '0) begin
            n_mismatched++;
            $display("[TB] FAIL rst_held: got v=%b data=%h, want 0/0", pix_if.o_pixel_data_valid, pix_if.o_pixel_data);
        end
        @(negedge i_clk);
        pix_if.i_pixel_valid = 1'b0;
        i_rst_n = 1'b1;
        model_reset();
        for (int p = 0; p < 16; p++) begin
            send(1'b1, p, 1'b0);
            n_compared++;
            if (fired) begin
                e = exp_q.pop_front();
                if (pix_if.o_pixel_data_valid !== 1'b1 || pix_if.o_pixel_data !== e.data || pix_if.o_frame_done !== e.done) begin
                    n_mismatched++;
                    $display("[TB] FAIL rst_window p=%0d: got v=%b d=%b data=%h, want v=1 d=%b data=%h",
                             p, pix_if.o_pixel_data_valid, pix_if.o_frame_done, pix_if.o_pixel_data, e.done, e.data);
                end
            end else if (pix_if.o_pixel_data_valid !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL rst_quiet p=%0d: got v=%b, want 0", p, pix_if.o_pixel_data_valid);
            end
            dut_wins += int'(pix_if.o_pixel_data_valid === 1'b1);
        end
        n_compared++;
        if (dut_wins != WINS_PER_FRAME) begin
            n_mismatched++;
            $display("[TB] FAIL rst_counts: got wins=%0d, want %0d", dut_wins, WINS_PER_FRAME);
        end
    endtask

`ifdef CONV_WIN_SOF_EN
    task automatic test_sof_resync();
        exp_t e;
        int   dut_wins = 0;
        int   dut_dones = 0;
        for (int p = 0; p < 7; p++) begin
            send(1'b1, p, 1'b0);
            if (p == 3) begin
                send(1'b0, 0, 1'b1);
            end
            n_compared++;
            if (pix_if.o_pixel_data_valid !== 1'b0 || pix_if.o_frame_done !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL sof_trunc_quiet p=%0d: got v=%b d=%b, want 0/0", p,
                         pix_if.o_pixel_data_valid, pix_if.o_frame_done);
            end
        end
        for (int p = 0; p < 16; p++) begin
            send(1'b1, p, p == 0);
            n_compared++;
            if (fired) begin
                e = exp_q.pop_front();
                if (pix_if.o_pixel_data_valid !== 1'b1 || pix_if.o_pixel_data !== e.data || pix_if.o_frame_done !== e.done) begin
                    n_mismatched++;
                    $display("[TB] FAIL sof_window p=%0d: got v=%b d=%b data=%h, want v=1 d=%b data=%h",
                             p, pix_if.o_pixel_data_valid, pix_if.o_frame_done, pix_if.o_pixel_data, e.done, e.data);
                end
            end else if (pix_if.o_pixel_data_valid !== 1'b0 || pix_if.o_frame_done !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL sof_quiet p=%0d: got v=%b d=%b, want 0/0", p,
                         pix_if.o_pixel_data_valid, pix_if.o_frame_done);
            end
            if (pix_if.o_pixel_data_valid === 1'b1 && dut_wins == 0) begin
                n_compared++;
                if (pix_if.o_pixel_data !== pack_taps(FIRST_TAPS)) begin
                    n_mismatched++;
                    $display("[TB] FAIL sof_first_window: got %h, want %h", pix_if.o_pixel_data, pack_taps(FIRST_TAPS));
                end
            end
            dut_wins  += int'(pix_if.o_pixel_data_valid === 1'b1);
            dut_dones += int'(pix_if.o_frame_done === 1'b1);
        end
        pix_if.i_sof = 1'b0;
        n_compared++;
        if (dut_wins != WINS_PER_FRAME || dut_dones != 1) begin
            n_mismatched++;
            $display("[TB] FAIL sof_counts: got wins=%0d dones=%0d, want %0d/1", dut_wins, dut_dones, WINS_PER_FRAME);
        end
    endtask
`endif

    initial begin
        pix_if.i_pixel       = '0;
        pix_if.i_pixel_valid = 1'b0;
`ifdef CONV_WIN_SOF_EN
        pix_if.i_sof         = 1'b0;
`endif
        model_reset();
        test_reset();
        test_continuous_frame();
        test_idle_gaps();
        test_back_to_back();
        test_mid_frame_reset();
`ifdef CONV_WIN_SOF_EN
        test_sof_resync();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
